// File: rtl/reg_file_rd.sv
// Architectural register file with two registered read ports and a $0 that always reads zero.
// Read data appears one cycle after the index is presented; a write bypasses into a read on the same edge.
// Stall freezes the read outputs and Flush zeroes them; writes are accepted every cycle regardless of either.
module reg_file_rd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] Result,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] DestRegReg,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic              ReadEn,
    input  logic              Stall,
    input  logic              Flush,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              ReadValid
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
    logic              writeHit;

    // A write is live only when enabled and not aimed at the hard-wired zero register.
    assign writeHit = RegWrite && (DestRegReg != '0);

    // Storage update: entry 0 is cleared on reset and never written, so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeHit) begin
            regs[DestRegReg] <= Result;
        end
    end

    // Operand selection: zero register first, then same-edge bypass, then stored value.
    always_comb begin
        operand1 = regs[ReadReg1];
        operand2 = regs[ReadReg2];
        if (ReadReg1 == '0) begin
            operand1 = '0;
        end else if (writeHit && (DestRegReg == ReadReg1)) begin
            operand1 = Result;
        end
        if (ReadReg2 == '0) begin
            operand2 = '0;
        end else if (writeHit && (DestRegReg == ReadReg2)) begin
            operand2 = Result;
        end
    end

    // Operand latch: Flush beats Stall beats ReadEn; an idle cycle keeps data but drops valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ReadData1 <= '0;
            ReadData2 <= '0;
            ReadValid <= 1'b0;
        end else if (Flush) begin
            ReadData1 <= '0;
            ReadData2 <= '0;
            ReadValid <= 1'b0;
        end else if (Stall) begin
            ReadData1 <= ReadData1;
            ReadData2 <= ReadData2;
            ReadValid <= ReadValid;
        end else if (ReadEn) begin
            ReadData1 <= operand1;
            ReadData2 <= operand2;
            ReadValid <= 1'b1;
        end else begin
            ReadValid <= 1'b0;
        end
    end

endmodule
